// File: rtl/lcd_byte_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lcd_pkg : state encoding, init ROM contents and timing helpers shared by the
//           HD44780 byte controller.                          Revision 1.0
// ----------------------------------------------------------------------------
package lcd_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_PWR_WAIT  = 4'd0;
  localparam state_t ST_INIT_SEND = 4'd1;
  localparam state_t ST_INIT_ACK  = 4'd2;
  localparam state_t ST_INIT_DLY  = 4'd3;
  localparam state_t ST_IDLE      = 4'd4;
  localparam state_t ST_HI_SEND   = 4'd5;
  localparam state_t ST_HI_ACK    = 4'd6;
  localparam state_t ST_GAP       = 4'd7;
  localparam state_t ST_LO_SEND   = 4'd8;
  localparam state_t ST_LO_ACK    = 4'd9;

  localparam int INIT_NIBBLE_COUNT = 4;
  localparam logic [3:0] INIT_NIBBLES [INIT_NIBBLE_COUNT] = '{4'h3, 4'h3, 4'h3, 4'h2};
  // 0 selects the long delay after the first nibble, 1 the short one
  localparam logic INIT_DLY_SEL [INIT_NIBBLE_COUNT] = '{1'b0, 1'b1, 1'b1, 1'b1};

  localparam int INIT_BYTES = 5;
  localparam logic [7:0] INIT_BYTE_ROM [INIT_BYTES] = '{8'h28, 8'h08, 8'h01, 8'h06, 8'h0C};

  function automatic int us_to_cycles(input int freq_hz, input int us);
    return (freq_hz / 1000000) * us;
  endfunction

  function automatic int sat_sub(input int value, input int amount);
    return (value > amount) ? (value - amount) : 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_delay_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lcd_delay_timer : loadable down-counter that stops at zero.
//                                                             Revision 1.0
// ----------------------------------------------------------------------------
module lcd_delay_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count,
  output logic             zero
);

  logic [WIDTH-1:0] remaining;

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= load_value;
    end else if (count && (remaining != '0)) begin
      remaining <= remaining - WIDTH'(1);
    end
  end

  assign zero = (remaining == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_byte_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lcd_byte_ctrl : HD44780 power-on init plus byte-to-nibble issue towards the
//                 4-bit transfer engine.                      Revision 1.0
// ----------------------------------------------------------------------------
module lcd_byte_ctrl
  import lcd_pkg::*;
#(
  parameter int FREQ       = 50000000,
  parameter int POWERUP_US = 40000,
  parameter int INIT1_US   = 4100,
  parameter int INIT2_US   = 100
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_rs,
  output logic       in_ready,
  output logic       init_done,
  output logic       sendCommand,
  output logic [3:0] command,
  output logic       command_rs,
  output logic       read_busy,
  output logic       mode4bit,
  input  logic       commandDone
);

  localparam int POWERUP_CYC = us_to_cycles(FREQ, POWERUP_US);
  localparam int INIT1_CYC   = us_to_cycles(FREQ, INIT1_US);
  localparam int INIT2_CYC   = us_to_cycles(FREQ, INIT2_US);
  localparam int MAX_CYC_A   = (POWERUP_CYC > INIT1_CYC) ? POWERUP_CYC : INIT1_CYC;
  localparam int MAX_CYC     = (MAX_CYC_A > INIT2_CYC) ? MAX_CYC_A : INIT2_CYC;
  localparam int TIMER_W_RAW = $clog2(MAX_CYC + 1);
  localparam int TIMER_W     = (TIMER_W_RAW < 2) ? 2 : TIMER_W_RAW;

  // Power-up is counted from the first out-of-reset cycle; the other waits
  // are measured from commandDone to the next sendCommand.
  localparam logic [TIMER_W-1:0] PWR_LOAD   = TIMER_W'(sat_sub(POWERUP_CYC, 1));
  localparam logic [TIMER_W-1:0] INIT1_LOAD = TIMER_W'(sat_sub(INIT1_CYC, 2));
  localparam logic [TIMER_W-1:0] INIT2_LOAD = TIMER_W'(sat_sub(INIT2_CYC, 2));
  localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(1);

  localparam logic [2:0] LAST_NIBBLE_IDX = 3'(INIT_NIBBLE_COUNT - 1);
  localparam logic [2:0] LAST_BYTE_IDX   = 3'(INIT_BYTES - 1);

  state_t             state;
  logic [2:0]         init_idx;
  logic [2:0]         next_idx;
  logic [2:0]         rom_sel;
  logic [7:0]         rom_first;
  logic [7:0]         rom_next;
  logic [7:0]         byte_reg;
  logic               rs_reg;
  logic               gap_to_lo;
  logic               pwr_armed;
  logic               accept;

  logic               timer_load;
  logic               timer_count;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_zero;

  logic               issue;
  logic [3:0]         issue_nib;
  logic               issue_rs;
  logic               issue_poll;

  assign in_ready  = init_done && (state == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign next_idx  = init_idx + 3'd1;
  assign rom_sel   = (init_idx == LAST_BYTE_IDX) ? init_idx : next_idx;
  assign rom_first = INIT_BYTE_ROM[0];
  assign rom_next  = INIT_BYTE_ROM[rom_sel];

  lcd_delay_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk        (CLK),
    .rst        (RESET),
    .load       (timer_load),
    .load_value (timer_value),
    .count      (timer_count),
    .zero       (timer_zero)
  );

  always_comb begin
    timer_load  = 1'b0;
    timer_count = 1'b0;
    timer_value = '0;
    case (state)
      ST_PWR_WAIT: begin
        if (!pwr_armed) begin
          timer_load  = 1'b1;
          timer_value = PWR_LOAD;
        end else begin
          timer_count = 1'b1;
        end
      end
      ST_INIT_ACK: begin
        if (commandDone) begin
          timer_load  = 1'b1;
          timer_value = INIT_DLY_SEL[init_idx[1:0]] ? INIT2_LOAD : INIT1_LOAD;
        end
      end
      ST_INIT_DLY, ST_GAP: timer_count = 1'b1;
      ST_HI_ACK, ST_LO_ACK: begin
        if (commandDone) begin
          timer_load  = 1'b1;
          timer_value = GAP_LOAD;
        end
      end
      default: ;
    endcase
  end

  // Every nibble launch is decided here so the registered outputs update together
  always_comb begin
    issue      = 1'b0;
    issue_nib  = 4'h0;
    issue_rs   = 1'b0;
    issue_poll = 1'b0;
    case (state)
      ST_PWR_WAIT: begin
        if (pwr_armed && timer_zero) begin
          issue     = 1'b1;
          issue_nib = INIT_NIBBLES[0];
        end
      end
      ST_INIT_DLY: begin
        if (timer_zero) begin
          issue     = 1'b1;
          issue_nib = (init_idx == LAST_NIBBLE_IDX) ? rom_first[7:4]
                                                    : INIT_NIBBLES[next_idx[1:0]];
        end
      end
      ST_IDLE: begin
        if (accept) begin
          issue     = 1'b1;
          issue_nib = in_data[7:4];
          issue_rs  = in_rs;
        end
      end
      ST_GAP: begin
        if (timer_zero) begin
          if (gap_to_lo) begin
            issue      = 1'b1;
            issue_nib  = byte_reg[3:0];
            issue_rs   = rs_reg;
            issue_poll = 1'b1;
          end else if (!init_done) begin
            issue     = 1'b1;
            issue_nib = rom_next[7:4];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_PWR_WAIT;
      init_idx    <= 3'd0;
      byte_reg    <= 8'h00;
      rs_reg      <= 1'b0;
      gap_to_lo   <= 1'b0;
      pwr_armed   <= 1'b0;
      init_done   <= 1'b0;
      sendCommand <= 1'b0;
      command     <= 4'h0;
      command_rs  <= 1'b0;
      read_busy   <= 1'b0;
      mode4bit    <= 1'b0;
    end else begin
      sendCommand <= issue;
      if (issue) begin
        command    <= issue_nib;
        command_rs <= issue_rs;
        read_busy  <= issue_poll;
        mode4bit   <= issue_poll;
      end
      case (state)
        ST_PWR_WAIT: begin
          pwr_armed <= 1'b1;
          if (issue) state <= ST_INIT_SEND;
        end
        ST_INIT_SEND: state <= ST_INIT_ACK;
        ST_INIT_ACK: if (commandDone) state <= ST_INIT_DLY;
        ST_INIT_DLY: begin
          if (timer_zero) begin
            if (init_idx == LAST_NIBBLE_IDX) begin
              init_idx <= 3'd0;
              byte_reg <= rom_first;
              rs_reg   <= 1'b0;
              state    <= ST_HI_SEND;
            end else begin
              init_idx <= next_idx;
              state    <= ST_INIT_SEND;
            end
          end
        end
        ST_IDLE: begin
          if (accept) begin
            byte_reg <= in_data;
            rs_reg   <= in_rs;
            state    <= ST_HI_SEND;
          end
        end
        ST_HI_SEND: state <= ST_HI_ACK;
        ST_HI_ACK: begin
          if (commandDone) begin
            gap_to_lo <= 1'b1;
            state     <= ST_GAP;
          end
        end
        ST_LO_SEND: state <= ST_LO_ACK;
        ST_LO_ACK: begin
          if (commandDone) begin
            gap_to_lo <= 1'b0;
            state     <= ST_GAP;
            if (!init_done && (init_idx == LAST_BYTE_IDX)) init_done <= 1'b1;
          end
        end
        ST_GAP: begin
          if (timer_zero) begin
            if (gap_to_lo) begin
              state <= ST_LO_SEND;
            end else if (init_done) begin
              state <= ST_IDLE;
            end else begin
              init_idx <= next_idx;
              byte_reg <= rom_next;
              rs_reg   <= 1'b0;
              state    <= ST_HI_SEND;
            end
          end
        end
        default: state <= ST_PWR_WAIT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_byte_ctrl.sv
`default_nettype none
// tb_lcd_byte_ctrl : directed bench with a nibble scoreboard and an engine
// model that answers each sendCommand with commandDone after a set delay.
module tb_lcd_byte_ctrl;

  localparam int FREQ       = 1000000;
  localparam int POWERUP_US = 40;
  localparam int INIT1_US   = 41;
  localparam int INIT2_US   = 10;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_rs = 1'b0;
  logic       commandDone = 1'b0;
  logic       in_ready;
  logic       init_done;
  logic       sendCommand;
  logic [3:0] command;
  logic       command_rs;
  logic       read_busy;
  logic       mode4bit;

  lcd_byte_ctrl #(
    .FREQ       (FREQ),
    .POWERUP_US (POWERUP_US),
    .INIT1_US   (INIT1_US),
    .INIT2_US   (INIT2_US)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_rs       (in_rs),
    .in_ready    (in_ready),
    .init_done   (init_done),
    .sendCommand (sendCommand),
    .command     (command),
    .command_rs  (command_rs),
    .read_busy   (read_busy),
    .mode4bit    (mode4bit),
    .commandDone (commandDone)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] nib;
    logic       rs;
    logic       poll;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         send_log[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         bfm_delay = 5;
  int         bfm_cnt = 0;
  bit         pending = 1'b0;
  bit         stab_err = 1'b0;
  int         last_done_cyc = -100;
  int         rel_base = 0;
  logic [6:0] held = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] nib, input logic rs, input logic poll);
    exp_t e;
    e.nib  = nib;
    e.rs   = rs;
    e.poll = poll;
    return e;
  endfunction

  // Monitor, scoreboard consumer and engine model, all sampled mid-cycle
  always @(negedge CLK) begin
    if (sendCommand) begin
      send_log.push_back(cyc);
      check("gap", 32'(cyc - last_done_cyc >= 3), 1);
      if (pending) stab_err = 1'b1;
      if (sb.size() == 0) begin
        check("unexpected_send", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("nibble", {command, command_rs, read_busy, mode4bit},
              {mon_e.nib, mon_e.rs, mon_e.poll, mon_e.poll});
      end
      held = {command, command_rs, read_busy, mode4bit};
    end else if (pending && ({command, command_rs, read_busy, mode4bit} !== held)) begin
      stab_err = 1'b1;
    end
    if (commandDone) commandDone = 1'b0;
    if (pending) begin
      bfm_cnt--;
      if (bfm_cnt == 0) begin
        commandDone   = 1'b1;
        pending       = 1'b0;
        last_done_cyc = cyc;
      end
    end else if (sendCommand) begin
      pending = 1'b1;
      bfm_cnt = bfm_delay;
    end
  end

  task automatic push_init();
    logic [3:0] nibs [14];
    nibs = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h6, 4'h0, 4'hC};
    for (int i = 0; i < 14; i++) begin
      sb.push_back(mk(nibs[i], 1'b0, (i >= 4) && ((i % 2) == 1)));
    end
  endtask

  task automatic wait_send(input int bound, input string tag);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!sendCommand && n < bound);
    check(tag, 32'(sendCommand), 1);
  endtask

  task automatic wait_ready(input int bound);
    int n = 0;
    while (!in_ready && n < bound) begin
      @(negedge CLK);
      n++;
    end
    check("ready_wait", 32'(in_ready), 1);
  endtask

  task automatic wait_init_done(input int bound);
    int n = 0;
    while (!init_done && n < bound) begin
      @(negedge CLK);
      n++;
    end
    check("init_done_wait", 32'(init_done), 1);
    check("init_done_after_last_ack", 32'(cyc - last_done_cyc), 1);
    check("init_stream_consumed", 32'(sb.size()), 0);
  endtask

  task automatic wait_drain(input int bound, output bit ready_seen);
    int n = 0;
    ready_seen = 1'b0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge CLK);
      n++;
      if (in_ready) ready_seen = 1'b1;
    end
    check("drain", 32'(sb.size()), 0);
  endtask

  task automatic send_byte(input logic [7:0] data, input logic rs);
    sb.push_back(mk(data[7:4], rs, 1'b0));
    sb.push_back(mk(data[3:0], rs, 1'b1));
    in_valid = 1'b1;
    in_data  = data;
    in_rs    = rs;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  initial begin
    bit ready_seen;
    bit will_accept;
    int acc;
    int n;

    // Reset state
    repeat (3) @(negedge CLK);
    check("reset_outputs",
          {in_ready, init_done, sendCommand, command, command_rs, read_busy, mode4bit}, 0);

    // Power-up wait and init nibble spacing
    push_init();
    RESET    = 1'b0;
    rel_base = cyc + 1;
    wait_send(100, "first_send_wait");
    check("first_send_cycle", 32'(cyc - rel_base), 40);
    check("first_nibble", {command, read_busy}, {4'h3, 1'b0});
    wait_init_done(2000);
    check("init_send_count", 32'(send_log.size()), 14);
    if (send_log.size() >= 5) begin
      check("init1_spacing", 32'(send_log[1] - send_log[0]), 46);
      check("init2_spacing", 32'(send_log[2] - send_log[1]), 15);
      check("init3_spacing", 32'(send_log[3] - send_log[2]), 15);
      check("init4_spacing", 32'(send_log[4] - send_log[3]), 15);
    end

    // Single data byte
    wait_ready(20);
    send_byte(8'h41, 1'b1);
    check("hi_latency", 32'(sendCommand), 1);
    check("ready_drop", 32'(in_ready), 0);
    wait_drain(200, ready_seen);
    check("ready_low_busy", 32'(ready_seen), 0);

    // Back-to-back bytes with in_valid held
    wait_ready(20);
    sb.push_back(mk(4'h4, 1'b0, 1'b0));
    sb.push_back(mk(4'h8, 1'b0, 1'b1));
    sb.push_back(mk(4'h4, 1'b0, 1'b0));
    sb.push_back(mk(4'h9, 1'b0, 1'b1));
    in_valid = 1'b1;
    in_data  = 8'h48;
    in_rs    = 1'b0;
    acc = 0;
    n   = 0;
    while (acc < 2 && n < 500) begin
      will_accept = in_ready;
      @(negedge CLK);
      n++;
      if (will_accept) begin
        acc++;
        in_data = 8'h49;
      end
    end
    in_valid = 1'b0;
    check("b2b_accepts", 32'(acc), 2);
    wait_drain(200, ready_seen);

    // Slow engine: outputs must hold while waiting for commandDone
    wait_ready(20);
    bfm_delay = 200;
    stab_err  = 1'b0;
    send_byte(8'h5A, 1'b1);
    wait_drain(1000, ready_seen);
    wait_ready(400);
    check("busy_stable", 32'(stab_err), 0);
    bfm_delay = 5;

    // Reset while the low nibble is outstanding
    wait_ready(20);
    send_byte(8'h33, 1'b1);
    wait_drain(100, ready_seen);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("reset_mid_xfer",
          {in_ready, init_done, sendCommand, command, command_rs, read_busy, mode4bit}, 0);
    RESET    = 1'b0;
    rel_base = cyc + 1;
    push_init();
    wait_send(100, "restart_send_wait");
    check("restart_first_send", 32'(cyc - rel_base), 40);
    wait_init_done(2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
